// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared types and defaults for the sequential divider.
//   - state_e : divider FSM states (FIX exists only when SEQ_DIVIDER_SIGNED_EN
//               is defined; it is the sign-correction stage).
//   - DEF_WIDTH / DEF_BLOCK : default operand width and subtractor block width.
//   - CNT_W : iteration counter width for the default operand width.
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN
package seq_divider_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 4;
  localparam int CNT_W     = $clog2(DEF_WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
`ifdef SEQ_DIVIDER_SIGNED_EN
    FIX,
`endif
    DONE
  } state_e;

endpackage

// File: rtl/borrow_bypass_sub.sv
// borrow_bypass_sub
//   Combinational N-bit subtractor diff_o = a_i - b_i built from BLOCK-bit
//   ripple blocks. A block whose bits are all pairwise equal passes its
//   borrow-in straight to its borrow-out; otherwise the ripple result is used.
// Ports:
//   a_i      [N-1:0]  minuend
//   b_i      [N-1:0]  subtrahend
//   diff_o   [N-1:0]  difference (mod 2^N)
//   borrow_o          borrow out of the top block (1 when a_i < b_i)
module borrow_bypass_sub #(
  parameter int N     = 33,
  parameter int BLOCK = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  localparam int NBLK = (N + BLOCK - 1) / BLOCK;

  // Bits beyond N in the last block behave as a=b=0: they propagate and
  // leave the ripple borrow untouched, so they are simply skipped.
  always_comb begin
    logic chain;
    logic rip;
    logic prop;
    diff_o = '0;
    chain  = 1'b0;
    rip    = 1'b0;
    prop   = 1'b1;
    for (int g = 0; g < NBLK; g++) begin
      rip  = chain;
      prop = 1'b1;
      for (int i = 0; i < BLOCK; i++) begin
        if (g * BLOCK + i < N) begin
          diff_o[g*BLOCK+i] = a_i[g*BLOCK+i] ^ b_i[g*BLOCK+i] ^ rip;
          rip  = (~a_i[g*BLOCK+i] & b_i[g*BLOCK+i]) |
                 (~(a_i[g*BLOCK+i] ^ b_i[g*BLOCK+i]) & rip);
          prop = prop & ~(a_i[g*BLOCK+i] ^ b_i[g*BLOCK+i]);
        end
      end
      chain = prop ? chain : rip;
    end
    borrow_o = chain;
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Radix-2 restoring divider, one quotient bit per clock, with valid/ready
//   handshakes on the operand and result sides.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid / in_ready  operand handshake (dividend, divisor)
//   out_valid / out_ready result handshake (quotient, remainder, div_by_zero)
// Optional feature macro: SEQ_DIVIDER_SIGNED_EN (two's-complement operands,
//   truncating division, one extra sign-correction cycle).
//
// state | meaning
// IDLE  | waiting for operands, in_ready=1
// RUN   | one restoring iteration per clock, WIDTH iterations
// FIX   | (signed build only) apply result signs
// DONE  | result held, out_valid=1 until consumed
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Dividend bits leave at the MSB while quotient bits enter at the LSB, so
  // after WIDTH iterations this register holds the quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  // The partial remainder is always below the divisor between iterations,
  // so its top bit is zero and only the lower WIDTH bits are stored.
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   trial_a;
  logic [WIDTH:0]   trial_diff;
  logic             trial_borrow;
  logic             unused_diff_msb;

  assign trial_a         = {rem_q, dvd_q[WIDTH-1]};
  assign unused_diff_msb = trial_diff[WIDTH];

  borrow_bypass_sub #(
    .N    (WIDTH + 1),
    .BLOCK(BLOCK)
  ) u_sub (
    .a_i     (trial_a),
    .b_i     ({1'b0, dvs_q}),
    .diff_o  (trial_diff),
    .borrow_o(trial_borrow)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic neg_quo_q, neg_quo_d;
  logic neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;

  assign dividend_mag = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
  assign divisor_mag  = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef SEQ_DIVIDER_SIGNED_EN
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cnt_d = '0;
          rem_d = '0;
          dbz_d = 1'b0;
          if (divisor == '0) begin
            dvd_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            dvd_d     = dividend_mag;
            dvs_d     = divisor_mag;
            neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_rem_d = dividend[WIDTH-1];
`else
            dvd_d = dividend;
            dvs_d = divisor;
`endif
            state_d = RUN;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = trial_borrow ? trial_a[WIDTH-1:0] : trial_diff[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], ~trial_borrow};
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_d = FIX;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef SEQ_DIVIDER_SIGNED_EN
      FIX: begin
        dvd_d   = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
        rem_d   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = dvd_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Directed vector table plus hand-written sequences for stalls and
//   mid-operation reset, and a batch of random pairs against a reference model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks   = 0;
  int failures = 0;

`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[$];

  seq_divider dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r,
                                output logic dbz);
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic [31:0] ma, mb, uq, ur;
`endif
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
    end else begin
      dbz = 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      ma = a[31] ? -a : a;
      mb = b[31] ? -b : b;
      uq = ma / mb;
      ur = ma % mb;
      q  = (a[31] ^ b[31]) ? -uq : uq;
      r  = a[31] ? -ur : ur;
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Called just after a rising edge; returns just after the edge that
  // completes the result handshake.
  task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    int cyc;
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    in_valid = 1'b0; dividend = '0; divisor = '0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({name, " latency"}, cyc, edbz ? 32'd1 : LAT);
    check({name, " quotient"}, quotient, eq);
    check({name, " remainder"}, remainder, er);
    check({name, " dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr, sq, sr;
    logic        rdbz;
    int          cyc;

`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs.push_back('{32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,        1'b0});
    vecs.push_back('{32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,        1'b0});
    vecs.push_back('{32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{32'd100,       32'd7,        32'd14,        32'd2,        1'b0});
    vecs.push_back('{32'd55,        32'd0,        32'hFFFF_FFFF, 32'd55,       1'b1});
    vecs.push_back('{32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFF, 32'hFFFF_FFFB, 1'b1});
    vecs.push_back('{32'h7FFF_FFFF, 32'd1,        32'h7FFF_FFFF, 32'd0,        1'b0});
`else
    vecs.push_back('{32'd100,       32'd7,        32'd14,        32'd2,        1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0,        1'b0});
    vecs.push_back('{32'h1234_5678, 32'h1234_5679, 32'd0,        32'h1234_5678, 1'b0});
    vecs.push_back('{32'd55,        32'd0,        32'hFFFF_FFFF, 32'd55,       1'b1});
    vecs.push_back('{32'd0,         32'd5,        32'd0,         32'd0,        1'b0});
    vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        32'd0,        1'b0});
    vecs.push_back('{32'h8000_0000, 32'd2,        32'h4000_0000, 32'd0,        1'b0});
    vecs.push_back('{32'd1000,      32'd3,        32'd333,       32'd1,        1'b0});
    vecs.push_back('{32'hDEAD_BEEF, 32'h10,       32'h0DEA_DBEE, 32'hF,        1'b0});
    vecs.push_back('{32'd0,         32'd0,        32'hFFFF_FFFF, 32'd0,        1'b1});
`endif

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", {31'd0, in_ready}, 32'd1);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset quotient", quotient, 32'd0);
    check("reset remainder", remainder, 32'd0);
    check("reset dbz", {31'd0, div_by_zero}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz);
    end

    // Result held with out_ready low while new operands are offered.
    in_valid = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("stall latency", cyc, LAT);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0]; dividend = 32'd9; divisor = 32'd4;
      @(posedge clk); #1;
      check("stall quotient", quotient, 32'd14);
      check("stall remainder", remainder, 32'd2);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("stall release out_valid", {31'd0, out_valid}, 32'd0);
    check("stall release in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("stall ignored in_valid", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of 1000/3.
    in_valid = 1'b1; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    check("midrst busy in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    run_div("after rst 9/4", 32'd9, 32'd4, 32'd2, 32'd1, 1'b0);

    // Random pairs, divisor magnitude spread by a random shift.
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 31);
      if (i % 37 == 0) rb = 32'd0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
`endif
      model(ra, rb, rq, rr, rdbz);
      run_div($sformatf("rnd%0d %h/%h", i, ra, rb), ra, rb, rq, rr, rdbz);
    end

    sq = quotient; sr = remainder;
    check("final in_ready", {31'd0, in_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
